// File: rtl/fnd_scan_decoder.sv
// Multiplexed 7-segment (FND) bus receiver: recovers a DIGITS-nibble word from an active-low segment
// bus plus a one-hot digit select. Optional macro FND_BLANK_EN decodes all-off digits as blank.
module fnd_scan_decoder #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic [6:0]            i_FND,
  input  logic [DIGITS-1:0]     i_Digit_Sel,
  output logic [4*DIGITS-1:0]   o_Data,
  output logic                  o_Valid,
  output logic                  o_Err,
`ifdef FND_BLANK_EN
  output logic [DIGITS-1:0]     o_Blank,
`endif
  output logic [DIGITS-1:0]     o_Digit_Err
);

  localparam int unsigned CW = $clog2(STABLE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CNT - 2);

  logic [6:0]              fnd_s1, fnd_s2, fnd_prev;
  logic [DIGITS-1:0]       sel_s1, sel_s2, sel_prev;
  logic [CW-1:0]           cnt;
  logic [DIGITS-1:0]       mask;
  logic [DIGITS-1:0][3:0]  hold_nib;
  logic [DIGITS-1:0]       hold_err;
`ifdef FND_BLANK_EN
  logic [DIGITS-1:0]       hold_blank;
`endif

  logic       same_c, legal_c, capture_c, frame_done_c;
  logic [3:0] dec_nib_c;
  logic       dec_err_c;
  logic       dec_blank_c;

  // Two-flop synchroniser plus one-cycle history for the stability compare
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fnd_s1   <= '0;
      fnd_s2   <= '0;
      fnd_prev <= '0;
      sel_s1   <= '0;
      sel_s2   <= '0;
      sel_prev <= '0;
    end else begin
      fnd_s1   <= i_FND;
      fnd_s2   <= fnd_s1;
      fnd_prev <= fnd_s2;
      sel_s1   <= i_Digit_Sel;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
    end
  end

  always_comb begin
    same_c       = (sel_s2 == sel_prev) && (fnd_s2 == fnd_prev);
    legal_c      = $onehot(sel_s2);
    capture_c    = legal_c && same_c && (cnt == CNT_ARM);
    frame_done_c = &mask;
  end

  // Segment pattern (g..a, active-low) back to a hex nibble
  always_comb begin
    dec_nib_c   = 4'h0;
    dec_err_c   = 1'b0;
    dec_blank_c = 1'b0;
    case (fnd_s2)
      7'b1000000: dec_nib_c = 4'h0;
      7'b1111001: dec_nib_c = 4'h1;
      7'b0100100: dec_nib_c = 4'h2;
      7'b0110000: dec_nib_c = 4'h3;
      7'b0011001: dec_nib_c = 4'h4;
      7'b0010010: dec_nib_c = 4'h5;
      7'b0000010: dec_nib_c = 4'h6;
      7'b1011000: dec_nib_c = 4'h7;
      7'b0000000: dec_nib_c = 4'h8;
      7'b0011000: dec_nib_c = 4'h9;
      7'b0001000: dec_nib_c = 4'hA;
      7'b0000011: dec_nib_c = 4'hB;
      7'b1000110: dec_nib_c = 4'hC;
      7'b0100001: dec_nib_c = 4'hD;
      7'b0000110: dec_nib_c = 4'hE;
      7'b0001110: dec_nib_c = 4'hF;
`ifdef FND_BLANK_EN
      7'b1111111: dec_blank_c = 1'b1;
`endif
      default:    dec_err_c = 1'b1;
    endcase
  end

  // Saturating stability counter; illegal select pins it at zero
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (!legal_c || !same_c) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Holding slots and capture mask; a capture on the completion edge seeds the next frame
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mask     <= '0;
      hold_nib <= '0;
      hold_err <= '0;
`ifdef FND_BLANK_EN
      hold_blank <= '0;
`endif
    end else begin
      if (frame_done_c) begin
        mask <= capture_c ? sel_s2 : '0;
      end else if (capture_c) begin
        mask <= mask | sel_s2;
      end
      for (int k = 0; k < int'(DIGITS); k++) begin
        if (capture_c && sel_s2[k]) begin
          hold_nib[k] <= dec_nib_c;
          hold_err[k] <= dec_err_c;
`ifdef FND_BLANK_EN
          hold_blank[k] <= dec_blank_c;
`endif
        end
      end
    end
  end

  // Output word loads once per completed frame and holds in between
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Data      <= '0;
      o_Valid     <= 1'b0;
      o_Err       <= 1'b0;
      o_Digit_Err <= '0;
`ifdef FND_BLANK_EN
      o_Blank     <= '0;
`endif
    end else begin
      o_Valid <= frame_done_c;
      if (frame_done_c) begin
        o_Data      <= hold_nib;
        o_Digit_Err <= hold_err;
        o_Err       <= |hold_err;
`ifdef FND_BLANK_EN
        o_Blank     <= hold_blank;
`endif
      end
    end
  end

`ifndef FND_BLANK_EN
  logic unused_blank;
  assign unused_blank = dec_blank_c;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder (DIGITS=4, STABLE_CNT=4); covers the FND_BLANK_EN build when defined.
module tb_fnd_scan_decoder;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
  localparam logic [6:0] P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1011000, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0011000, PB = 7'b0000011, PF = 7'b0001110;
  localparam logic [6:0] PBAD = 7'b1010101, POFF = 7'b1111111;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic [6:0]  i_FND = '0;
  logic [3:0]  i_Digit_Sel = '0;
  logic [15:0] o_Data;
  logic        o_Valid;
  logic        o_Err;
  logic [3:0]  o_Digit_Err;
`ifdef FND_BLANK_EN
  logic [3:0]  o_Blank;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base;

  fnd_scan_decoder #(.DIGITS(4), .STABLE_CNT(4)) dut (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_FND       (i_FND),
    .i_Digit_Sel (i_Digit_Sel),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .o_Err       (o_Err),
`ifdef FND_BLANK_EN
    .o_Blank     (o_Blank),
`endif
    .o_Digit_Err (o_Digit_Err)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) if (o_Valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [3:0] sel, input logic [6:0] fnd, input int n);
    repeat (n) begin
      @(negedge i_Clk);
      i_Digit_Sel = sel;
      i_FND = fnd;
    end
  endtask

  task automatic idle(input int n);
    show(4'b0000, 7'b0000000, n);
  endtask

  initial begin
    // Reset held with random inputs
    repeat (4) begin
      @(negedge i_Clk);
      i_FND = 7'($urandom);
      i_Digit_Sel = 4'($urandom);
    end
    #1;
    chk("rst_data", 32'(o_Data), 32'h0);
    chk("rst_valid", 32'(o_Valid), 32'h0);
    chk("rst_err", 32'(o_Err), 32'h0);
    chk("rst_digerr", 32'(o_Digit_Err), 32'h0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    i_FND = '0;
    i_Digit_Sel = '0;
    base = pulses;
    idle(10);
    chk("idle_no_pulse", 32'(pulses - base), 32'd0);

    // Clean frame 0123
    base = pulses;
    show(4'b0001, P3, 6);
    show(4'b0010, P2, 6);
    show(4'b0100, P1, 6);
    show(4'b1000, P0, 6);
    idle(8);
    chk("f1_pulses", 32'(pulses - base), 32'd1);
    chk("f1_data", 32'(o_Data), 32'h0123);
    chk("f1_err", 32'(o_Err), 32'h0);
    chk("f1_digerr", 32'(o_Digit_Err), 32'h0);

    // Unrecognised pattern on digit 1
    base = pulses;
    show(4'b0001, P3, 6);
    show(4'b0010, PBAD, 6);
    show(4'b0100, P1, 6);
    show(4'b1000, P0, 6);
    idle(8);
    chk("f2_pulses", 32'(pulses - base), 32'd1);
    chk("f2_data", 32'(o_Data), 32'h0103);
    chk("f2_err", 32'(o_Err), 32'h1);
    chk("f2_digerr", 32'(o_Digit_Err), 32'h2);

    // Three-cycle holds never capture
    base = pulses;
    show(4'b0001, P5, 3);
    show(4'b0010, P6, 3);
    show(4'b0100, P7, 3);
    show(4'b1000, P9, 3);
    idle(10);
    chk("short_no_pulse", 32'(pulses - base), 32'd0);
    chk("short_data_hold", 32'(o_Data), 32'h0103);

    // Multi-hot glitch mid-scan, then exact four-cycle holds
    base = pulses;
    show(4'b0001, P5, 4);
    show(4'b0010, P6, 2);
    show(4'b0011, P6, 1);
    show(4'b0010, P6, 4);
    show(4'b0100, P7, 4);
    show(4'b1000, P9, 4);
    idle(8);
    chk("glitch_pulses", 32'(pulses - base), 32'd1);
    chk("glitch_data", 32'(o_Data), 32'h9765);
    chk("glitch_err", 32'(o_Err), 32'h0);
    chk("glitch_digerr", 32'(o_Digit_Err), 32'h0);

    // Slot 0 rewritten before the frame completes
    base = pulses;
    show(4'b0001, P7, 5);
    show(4'b0001, P8, 5);
    show(4'b0010, PF, 5);
    show(4'b0100, PF, 5);
    show(4'b1000, PF, 5);
    idle(8);
    chk("rewrite_pulses", 32'(pulses - base), 32'd1);
    chk("rewrite_data", 32'(o_Data), 32'hFFF8);

    // Reset after three captures discards the partial frame
    show(4'b0001, P5, 5);
    show(4'b0010, P5, 5);
    show(4'b0100, P5, 5);
    idle(4);
    @(negedge i_Clk);
    i_Rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(o_Data), 32'h0);
    chk("midrst_valid", 32'(o_Valid), 32'h0);
    chk("midrst_err", 32'(o_Err), 32'h0);
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    base = pulses;
    show(4'b1000, PB, 5);
    idle(8);
    chk("midrst_no_stale_pulse", 32'(pulses - base), 32'd0);
    chk("midrst_data_hold", 32'(o_Data), 32'h0);
    show(4'b0001, PB, 5);
    show(4'b0010, PB, 5);
    show(4'b0100, PB, 5);
    idle(8);
    chk("after_rst_pulses", 32'(pulses - base), 32'd1);
    chk("after_rst_data", 32'(o_Data), 32'hBBBB);
    chk("after_rst_err", 32'(o_Err), 32'h0);

    // All-off pattern on digit 3
    base = pulses;
    show(4'b0001, PB, 5);
    show(4'b0010, PB, 5);
    show(4'b0100, PB, 5);
    show(4'b1000, POFF, 5);
    idle(8);
    chk("off_pulses", 32'(pulses - base), 32'd1);
    chk("off_data", 32'(o_Data), 32'h0BBB);
`ifdef FND_BLANK_EN
    chk("off_blank", 32'(o_Blank), 32'h8);
    chk("off_err", 32'(o_Err), 32'h0);
    chk("off_digerr", 32'(o_Digit_Err), 32'h0);
`else
    chk("off_err", 32'(o_Err), 32'h1);
    chk("off_digerr", 32'(o_Digit_Err), 32'h8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
